// File: rtl/mips_pkg.sv
// Fetch-side shared types: address/instruction widths,
// reset PC, fetch FSM states and the queue entry layout.
package mips_pkg;
  localparam int AW = 30;
  localparam int IW = 32;
  localparam logic [AW-1:0] RESET_PC = 30'h00000C00;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode-side
// instruction handshake of the fetch unit.
interface fetch_unit_if;
  import mips_pkg::*;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Shift-register instruction queue; entry 0 is the head,
// so head data and valid come straight from flops.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic         valid,
  output logic [CW-1:0] count
);
  fetch_entry_t     mem  [DEPTH];
  fetch_entry_t     nmem [DEPTH];
  logic [DEPTH-1:0] vld, nvld;
  logic [CW-1:0]    ncnt;
  logic             take;

  assign take  = pop & vld[0];
  assign dout  = mem[0];
  assign valid = vld[0];

  always_comb begin
    nmem = mem;
    nvld = vld;
    ncnt = count;
    if (take) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        nmem[i] = mem[i+1];
      end
      nvld = vld >> 1;
      ncnt = count - CW'(1);
    end
    // write lands behind whatever survives the pop
    if (push && ncnt != CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == ncnt) begin
          nmem[i] = din;
          nvld[i] = 1'b1;
        end
      end
      ncnt = ncnt + CW'(1);
    end
    if (flush) begin
      nvld = '0;
      ncnt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld   <= '0;
      count <= '0;
    end else begin
      mem   <= nmem;
      vld   <= nvld;
      count <= ncnt;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, redirect
// with flush, and a small queue towards decode.
module fetch_unit #(
  parameter logic [mips_pkg::AW-1:0] RESET_PC =
    mips_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect,
  input  logic [mips_pkg::AW-1:0] npc_in,
  fetch_unit_if.master            bus
);
  import mips_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state, nstate;
  logic [AW-1:0] fetch_pc, npc;
  logic          req, push, pop;
  logic [CW-1:0] count;
  fetch_entry_t  wdata, head;
  logic          head_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= nstate;
      fetch_pc <= npc;
    end
  end

  always_comb begin
    nstate = state;
    npc    = fetch_pc;
    req    = 1'b0;
    push   = 1'b0;
    unique case (state)
      IDLE: nstate = REQ;
      REQ: begin
        req = count < CW'(DEPTH);
        if (req && bus.imem_gnt) begin
          npc    = fetch_pc + AW'(1);
          nstate = redirect ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push   = !redirect;
          nstate = REQ;
        end else if (redirect) begin
          nstate = DROP;
        end
      end
      DROP: if (bus.imem_rvalid) nstate = REQ;
      default: nstate = IDLE;
    endcase
    if (redirect) npc = npc_in;
  end

  // in WAIT the granted address is always one behind fetch_pc
  assign wdata = '{pc: fetch_pc - AW'(1),
                   inst: bus.imem_rdata};
  assign pop   = head_vld & bus.inst_ready;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .din   (wdata),
    .pop   (pop),
    .dout  (head),
    .valid (head_vld),
    .count (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = head_vld;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
endmodule
